mem_stage_sram_ctrl: RTL

MEM_STAGE_SRAM_CTRL -- requirements
Module: mem_stage_sram_ctrl

---
 rtl/mem_stage_sram_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: MEM pipeline stage that splits 32-bit loads/stores into two 16-bit SRAM accesses, freezing the pipeline (ready=0) while busy; ports: clk/rst, EXE/MEM inputs (*_in), ready, MEM/WB outputs (wb_en, mem_read, ALU_result, mem_data, dest), SRAM pins (sram_addr, sram_we_n, sram_dq_out/oe/in)
module mem_stage_sram_ctrl #(
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en_in,
  input  logic                   mem_read_in,
  input  logic                   mem_write_in,
  input  logic [31:0]            ALU_result_in,
  input  logic [31:0]            valRm_in,
  input  logic [3:0]             dest_in,
  output logic                   ready,
  output logic                   wb_en,
  output logic                   mem_read,
  output logic [31:0]            ALU_result,
  output logic [31:0]            mem_data,
  output logic [3:0]             dest,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam logic [2:0] LAST = 3'(WAIT_STATES);
  state_t state, state_nx;
  logic [2:0] phase;
  logic [15:0] lo_q, hi_q;
  logic req, load, busy, last;
  assign req = mem_read_in | mem_write_in;
  assign load = mem_read_in & ~mem_write_in;
  assign busy = state == LOW || state == HIGH;
  assign last = phase == LAST;
  assign sram_addr = {ALU_result_in[SRAM_ADDR_W:2], state == HIGH};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = req ? LOW : IDLE;
      LOW:  state_nx = last ? HIGH : LOW;
      HIGH: state_nx = last ? DONE : HIGH;
      DONE: state_nx = IDLE;
    endcase
    ready = state == DONE || (state == IDLE && !req);
    sram_dq_oe = busy && mem_write_in;
    sram_we_n = !sram_dq_oe;
    sram_dq_out = state == HIGH ? valRm_in[31:16] : valRm_in[15:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      state <= state_nx;
      phase <= (busy && state_nx == state) ? phase + 3'd1 : 3'd0;
      if (load && state == LOW && last) lo_q <= sram_dq_in;
      if (load && state == HIGH && last) hi_q <= sram_dq_in;
    end
  end
  // stalled edges inject a bubble: only the control bits are cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en <= 1'b0;
      mem_read <= 1'b0;
      ALU_result <= '0;
      mem_data <= '0;
      dest <= '0;
    end else if (ready) begin
      wb_en <= wb_en_in;
      mem_read <= mem_read_in;
      ALU_result <= ALU_result_in;
      dest <= dest_in;
      if (load) mem_data <= {hi_q, lo_q};
    end else begin
      wb_en <= 1'b0;
      mem_read <= 1'b0;
    end
  end
endmodule
